// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: converts four 8-bit values to two-digit decimal and scans them
// onto an 8-position multiplexed seven-segment display (active-low anodes/segments).
// Optional build macro: SEG_BLANK_LEADING_ZERO_EN blanks a zero tens digit of a
// non-overflowed slot (its anode keeps scanning).
//
// state | meaning
// IDLE  | one-cycle gap between conversion rounds, idx reset to 0
// LOAD  | sample val[idx], clear tens, flag overflow when >= 100
// DIV   | repeated subtraction of 10 until remainder < 10
// STORE | write {ovf, tens, ones} into slot idx, advance or finish round
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] val0,
  input  logic [7:0] val1,
  input  logic [7:0] val2,
  input  logic [7:0] val3,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       upd
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, STORE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  tmp_q, tmp_d;
  logic [3:0]  tens_q, tens_d;
  logic        ovf_q, ovf_d;
  logic        store_en;
  logic        upd_q, upd_d;
  logic [8:0]  slot_q [4];
  logic [7:0]  val_sel;

  logic [PW-1:0] psc_q;
  logic [2:0]    sidx_q;
  logic          tick;

  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic [8:0]  sel_slot;
  logic [3:0]  digit;

  // select the input value for the slot currently being loaded
  always_comb begin
    val_sel = val0;
    case (idx_q)
      2'd0:    val_sel = val0;
      2'd1:    val_sel = val1;
      2'd2:    val_sel = val2;
      default: val_sel = val3;
    endcase
  end

  // conversion FSM next-state and datapath
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmp_d    = tmp_q;
    tens_d   = tens_q;
    ovf_d    = ovf_q;
    store_en = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d   = 2'd0;
        state_d = LOAD;
      end
      LOAD: begin
        tmp_d  = val_sel;
        tens_d = 4'd0;
        if (val_sel >= 8'd100) begin
          ovf_d   = 1'b1;
          state_d = STORE;
        end else begin
          ovf_d   = 1'b0;
          state_d = DIV;
        end
      end
      DIV: begin
        if (tmp_q >= 8'd10) begin
          tmp_d  = tmp_q - 8'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          state_d = STORE;
        end
      end
      STORE: begin
        store_en = 1'b1;
        if (idx_q == 2'd3) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    upd_d = store_en && (idx_q == 2'd3);
  end

  // conversion FSM registers; the done pulse lands in the cycle after the last STORE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      tmp_q   <= 8'd0;
      tens_q  <= 4'd0;
      ovf_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmp_q   <= tmp_d;
      tens_q  <= tens_d;
      ovf_q   <= ovf_d;
      upd_q   <= upd_d;
    end
  end

  // digit slots only change on STORE, so the display never sees a partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
    end else if (store_en) begin
      slot_q[idx_q] <= {ovf_q, tens_q, tmp_q[3:0]};
    end
  end

  assign tick = en && (psc_q == PSC_LAST);

  // dwell prescaler and scan index; both freeze while the display is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q  <= '0;
      sidx_q <= 3'd0;
    end else if (en) begin
      psc_q <= tick ? '0 : psc_q + PW'(1);
      if (tick) sidx_q <= sidx_q + 3'd1;
    end
  end

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'h40;
      4'd1:    dec7 = 7'h79;
      4'd2:    dec7 = 7'h24;
      4'd3:    dec7 = 7'h30;
      4'd4:    dec7 = 7'h19;
      4'd5:    dec7 = 7'h12;
      4'd6:    dec7 = 7'h02;
      4'd7:    dec7 = 7'h78;
      4'd8:    dec7 = 7'h00;
      4'd9:    dec7 = 7'h10;
      default: dec7 = 7'h7F;
    endcase
  endfunction

  // even positions show ones, odd positions show tens of slot sidx/2
  always_comb begin
    sel_slot = slot_q[sidx_q[2:1]];
    digit    = sidx_q[0] ? sel_slot[7:4] : sel_slot[3:0];
    an_d     = 8'hFF;
    seg_d    = 7'h7F;
    if (en) begin
      an_d = ~(8'h01 << sidx_q);
      if (sel_slot[8]) begin
        seg_d = 7'h3F;
      end else begin
`ifdef SEG_BLANK_LEADING_ZERO_EN
        if (sidx_q[0] && (sel_slot[7:4] == 4'd0)) seg_d = 7'h7F;
        else                                     seg_d = dec7(digit);
`else
        seg_d = dec7(digit);
`endif
      end
    end
  end

  // registered display outputs, one cycle behind the scan index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= 8'hFF;
      seg_q <= 7'h7F;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign upd = upd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with SCAN_DIV=4: reference model derives display codes
// and conversion-round length directly from decimal arithmetic on the inputs.
module tb_seg_scan_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] val0, val1, val2, val3;
  logic [7:0] an;
  logic [6:0] seg;
  logic       upd;

  int tests = 0;
  int fails = 0;
  int cur_v [4];
  logic [6:0] dec_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seg_scan_ctrl #(.SCAN_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .an(an), .seg(seg), .upd(upd)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_vals(input int a, input int b, input int c, input int d);
    cur_v[0] = a; cur_v[1] = b; cur_v[2] = c; cur_v[3] = d;
    val0 = 8'(a); val1 = 8'(b); val2 = 8'(c); val3 = 8'(d);
  endtask

  // expected segment code for display position pos from the decimal value of its slot
  function automatic logic [6:0] exp_seg(input int pos);
    int v, dg;
    v = cur_v[pos / 2];
    if (v >= 100) return 7'h3F;
    dg = (pos % 2 == 1) ? v / 10 : v % 10;
`ifdef SEG_BLANK_LEADING_ZERO_EN
    if ((pos % 2 == 1) && (v / 10 == 0)) return 7'h7F;
`endif
    return dec_tbl[dg];
  endfunction

  // cycles from an upd pulse (or reset release) to the next upd pulse:
  // one IDLE cycle, then per slot LOAD + (v/10+1) DIV cycles + STORE
  // (overflowed slots: LOAD + STORE), then the pulse itself
  function automatic int conv_len();
    int s;
    s = 1;
    for (int i = 0; i < 4; i++)
      s += (cur_v[i] >= 100) ? 2 : 3 + cur_v[i] / 10;
    return s;
  endfunction

  task automatic wait_upd(input string tag, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      n++;
      if (upd) begin got = 1'b1; break; end
    end
    if (!got) chk({tag, "_timeout"}, 0, 1);
  endtask

  // sweep all eight positions from the start of an an[0] dwell and once more into an[0]
  task automatic scan_check(input string tag);
    bit ok;
    int cnt;
    logic [7:0] ea;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (an == 8'h7F) begin ok = 1'b1; break; end
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (an != 8'h7F) begin ok = 1'b1; break; end
      end
    end
    chk({tag, "_sync"}, 32'(ok), 1);
    if (!ok) return;
    for (int k = 0; k < 9; k++) begin
      ea = ~(8'h01 << (k % 8));
      chk($sformatf("%s_an_p%0d", tag, k), 32'(an), 32'(ea));
      chk($sformatf("%s_seg_p%0d", tag, k), 32'(seg), 32'(exp_seg(k % 8)));
      if (k < 8) begin
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          if (an == ea) cnt++;
          else break;
        end
        chk($sformatf("%s_dwell_p%0d", tag, k), 32'(cnt), D);
      end
    end
  endtask

  initial begin
    int n;
    int cnt;
    int upds;

    // reset held with clock running
    rst_n = 1'b0;
    en    = 1'b1;
    set_vals(69, 0, 10, 99);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_upd", 32'(upd), 0);

    // first round latency after release, round period, pulse width
    rst_n = 1'b1;
    wait_upd("first_upd", n);
    chk("first_upd_latency", n, conv_len());
    wait_upd("period0", n);
    chk("upd_period0", n, conv_len());
    @(posedge clk); #1;
    chk("upd_one_cycle", 32'(upd), 0);

    // directed decimal conversion and full scan order
    scan_check("dir69");

    // directed overflow
    set_vals(7, 42, 100, 255);
    wait_upd("ovf_a", n);
    wait_upd("ovf_b", n);
    chk("upd_period_ovf", n, conv_len());
    scan_check("ovf");

    // randomized values checked against the decimal model
    for (int t = 0; t < 4; t++) begin
      set_vals($urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(0, 255));
      wait_upd("rnd_a", n);
      wait_upd("rnd_b", n);
      chk($sformatf("upd_period_rnd%0d", t), n, conv_len());
      scan_check($sformatf("rnd%0d", t));
    end

    // display disabled mid-dwell; all overflowed keeps the round shorter than 10 cycles
    set_vals($urandom_range(100, 255), $urandom_range(100, 255),
             $urandom_range(100, 255), $urandom_range(100, 255));
    wait_upd("en_a", n);
    wait_upd("en_b", n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (an == 8'h7F) break;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (an != 8'h7F) break;
    end
    chk("en_pre_an0", 32'(an), 32'hFE);
    @(posedge clk); #1;
    chk("en_pre_an0_b", 32'(an), 32'hFE);
    en = 1'b0;
    upds = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (upd) upds++;
      if (i == 0 || i == 9) begin
        chk($sformatf("en_off_an_%0d", i), 32'(an), 32'hFF);
        chk($sformatf("en_off_seg_%0d", i), 32'(seg), 32'h7F);
      end
    end
    chk("en_off_upd_seen", 32'(upds >= 1), 1);
    en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (an == 8'hFE) cnt++;
      else break;
    end
    chk("en_resume_remaining_dwell", cnt, D - 2);
    chk("en_resume_next_pos", 32'(an), 32'hFD);

    // reset during slot 1's DIV phase
    set_vals(5, 95, 3, 3);
    wait_upd("rdiv_a", n);
    wait_upd("rdiv_b", n);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rdiv_an", 32'(an), 32'hFF);
    chk("rdiv_seg", 32'(seg), 32'h7F);
    chk("rdiv_upd", 32'(upd), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdiv_first_an", 32'(an), 32'hFE);
    chk("rdiv_slot0_cleared", 32'(seg), 32'h40);
    wait_upd("rdiv_restart", n);
    chk("rdiv_restart_latency", n + 1, conv_len());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
